// File: rtl/range_gate_pkg.sv
// Shared constants and parser state type for the range-gate generator.
// Frame layout: header, control, 4-byte delay, 4-byte width, XOR checksum.
package range_gate_pkg;

  localparam logic [7:0]  FRAME_HDR = 8'hBD;
  localparam int unsigned FRAME_LEN = 11;

  localparam logic [3:0] OFF_CTRL = 4'd1;
  localparam logic [3:0] OFF_DLY  = 4'd2;
  localparam logic [3:0] OFF_WID  = 4'd6;
  localparam logic [3:0] OFF_CSUM = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBody,
    StDiscard
  } parser_state_e;

endpackage

// File: rtl/range_gate_gen_if.sv
// Fire marker, host config byte stream and gate/status outputs of range_gate_gen.
interface range_gate_gen_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              tstart;
  logic [7:0]        cfg_data;
  logic              cfg_valid;
  logic              cfg_last;
  logic [NUM_CH-1:0] gate_out;
  logic              busy;
  logic              cfg_done;
  logic              cfg_err;

  modport master (
    output tstart, cfg_data, cfg_valid, cfg_last,
    input  gate_out, busy, cfg_done, cfg_err
  );

  modport slave (
    input  tstart, cfg_data, cfg_valid, cfg_last,
    output gate_out, busy, cfg_done, cfg_err
  );
endinterface

// File: rtl/gate_cfg_parser.sv
// Host frame parser: collects one 11-byte channel-timing frame, verifies it and
// presents the decoded fields alongside a one-cycle done or error pulse.
module gate_cfg_parser
  import range_gate_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       cfg_data_i,
  input  logic             cfg_valid_i,
  input  logic             cfg_last_i,
  output logic             cfg_done_o,
  output logic             cfg_err_o,
  output logic [3:0]       frm_ch_o,
  output logic             frm_en_o,
  output logic [CNT_W-1:0] frm_dly_o,
  output logic [CNT_W-1:0] frm_wid_o
);

  parser_state_e state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic          en_q, en_d;
  logic [3:0]    ch_q, ch_d;
  logic [31:0]   dly_q, dly_d;
  logic [31:0]   wid_q, wid_d;
  logic [7:0]    csum_q, csum_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          frame_ok;

  assign frame_ok = (csum_q == cfg_data_i) && ({28'd0, ch_q} < NUM_CH) && cfg_last_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    ch_d    = ch_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (cfg_valid_i) begin
      unique case (state_q)
        StIdle: begin
          if (cfg_data_i == FRAME_HDR) begin
            state_d = StBody;
            idx_d   = OFF_CTRL;
            csum_d  = 8'h00;
          end else if (!cfg_last_i) begin
            // A lone junk byte that already carries cfg_last ends its own frame.
            state_d = StDiscard;
          end
        end
        StDiscard: begin
          if (cfg_last_i) state_d = StIdle;
        end
        StBody: begin
          idx_d  = idx_q + 4'd1;
          csum_d = csum_q ^ cfg_data_i;
          if (idx_q == OFF_CTRL) begin
            en_d = cfg_data_i[7];
            ch_d = cfg_data_i[3:0];
          end else if (idx_q >= OFF_DLY && idx_q < OFF_WID) begin
            dly_d = {dly_q[23:0], cfg_data_i};
          end else if (idx_q >= OFF_WID && idx_q < OFF_CSUM) begin
            wid_d = {wid_q[23:0], cfg_data_i};
          end
          if (idx_q == OFF_CSUM) begin
            done_d  = frame_ok;
            err_d   = !frame_ok;
            state_d = cfg_last_i ? StIdle : StDiscard;
          end else if (cfg_last_i) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      en_q    <= 1'b0;
      ch_q    <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      ch_q    <= ch_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cfg_done_o = done_q;
  assign cfg_err_o  = err_q;
  assign frm_ch_o   = ch_q;
  assign frm_en_o   = en_q;
  assign frm_dly_o  = CNT_W'(dly_q);
  assign frm_wid_o  = CNT_W'(wid_q);

endmodule

// File: rtl/range_gate_gen.sv
// Multi-channel range-gate generator: a synchronised fire marker starts a shared
// time-base and each channel gates a programmable [delay, delay+width) window.
module range_gate_gen
  import range_gate_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 3
) (
  input logic              clk,
  input logic              rst_n,
  range_gate_gen_if.slave  bus
);

  typedef logic [CNT_W:0] ext_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;
  logic                   rise_q, rise_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]      gate_q, gate_d;

  logic [NUM_CH-1:0]      en_q, en_d;
  logic [CNT_W-1:0]       dly_q [NUM_CH];
  logic [CNT_W-1:0]       dly_d [NUM_CH];
  logic [CNT_W-1:0]       wid_q [NUM_CH];
  logic [CNT_W-1:0]       wid_d [NUM_CH];

  logic                   pend_vld_q, pend_vld_d;
  logic [3:0]             pend_ch_q, pend_ch_d;
  logic                   pend_en_q, pend_en_d;
  logic [CNT_W-1:0]       pend_dly_q, pend_dly_d;
  logic [CNT_W-1:0]       pend_wid_q, pend_wid_d;

  logic                   frm_done;
  logic [3:0]             frm_ch;
  logic                   frm_en;
  logic [CNT_W-1:0]       frm_dly;
  logic [CNT_W-1:0]       frm_wid;

  ext_t                   chan_end [NUM_CH];
  logic [NUM_CH-1:0]      chan_qual;
  ext_t                   end_max;
  logic                   apply;

  gate_cfg_parser #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_data_i  (bus.cfg_data),
    .cfg_valid_i (bus.cfg_valid),
    .cfg_last_i  (bus.cfg_last),
    .cfg_done_o  (frm_done),
    .cfg_err_o   (bus.cfg_err),
    .frm_ch_o    (frm_ch),
    .frm_en_o    (frm_en),
    .frm_dly_o   (frm_dly),
    .frm_wid_o   (frm_wid)
  );

  // Comparators run one bit wider than the time-base so delay+width never wraps.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    assign chan_end[k]  = {1'b0, dly_q[k]} + {1'b0, wid_q[k]};
    assign chan_qual[k] = en_q[k] && (wid_q[k] != '0);
    assign gate_d[k]    = busy_q && chan_qual[k] && (cnt_q >= dly_q[k]) &&
                          ({1'b0, cnt_q} < chan_end[k]);
  end

  always_comb begin
    end_max = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (chan_qual[k] && (chan_end[k] > end_max)) end_max = chan_end[k];
    end
  end

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.tstart};
    rise_d = sync_q[SYNC_STAGES-1] && !prev_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (({1'b0, cnt_q} + ext_t'(1)) >= end_max) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (rise_q) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end
  end

  // The channel table only changes between shots; a pending frame waits for idle.
  assign apply = pend_vld_q && !busy_q;

  always_comb begin
    en_d       = en_q;
    dly_d      = dly_q;
    wid_d      = wid_q;
    pend_vld_d = pend_vld_q;
    pend_ch_d  = pend_ch_q;
    pend_en_d  = pend_en_q;
    pend_dly_d = pend_dly_q;
    pend_wid_d = pend_wid_q;
    if (apply) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (pend_ch_q == 4'(k)) begin
          en_d[k]  = pend_en_q;
          dly_d[k] = pend_dly_q;
          wid_d[k] = pend_wid_q;
        end
      end
      pend_vld_d = 1'b0;
    end
    if (frm_done) begin
      pend_vld_d = 1'b1;
      pend_ch_d  = frm_ch;
      pend_en_d  = frm_en;
      pend_dly_d = frm_dly;
      pend_wid_d = frm_wid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      prev_q     <= 1'b0;
      rise_q     <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      gate_q     <= '0;
      en_q       <= '0;
      dly_q      <= '{default: '0};
      wid_q      <= '{default: '0};
      pend_vld_q <= 1'b0;
      pend_ch_q  <= '0;
      pend_en_q  <= 1'b0;
      pend_dly_q <= '0;
      pend_wid_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= sync_q[SYNC_STAGES-1];
      rise_q     <= rise_d;
      busy_q     <= busy_d;
      cnt_q      <= cnt_d;
      gate_q     <= gate_d;
      en_q       <= en_d;
      dly_q      <= dly_d;
      wid_q      <= wid_d;
      pend_vld_q <= pend_vld_d;
      pend_ch_q  <= pend_ch_d;
      pend_en_q  <= pend_en_d;
      pend_dly_q <= pend_dly_d;
      pend_wid_q <= pend_wid_d;
    end
  end

  assign bus.gate_out = gate_q;
  assign bus.busy     = busy_q;
  assign bus.cfg_done = frm_done;

endmodule

// File: tb/tb_range_gate_gen.sv
// Self-checking bench for range_gate_gen: frames and shots compared against a
// shot-level model of gate windows and busy duration.
module tb_range_gate_gen;

  localparam int NUM_CH = 4;
  localparam int S      = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  range_gate_gen_if #(.NUM_CH(NUM_CH)) bus ();

  range_gate_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (32),
    .SYNC_STAGES (S)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: channel table as the host last successfully programmed it.
  bit m_en  [NUM_CH];
  int m_dly [NUM_CH];
  int m_wid [NUM_CH];

  // Observations of the last shot, in cycles after the edge that samples the rise.
  int obs_first [NUM_CH];
  int obs_cnt   [NUM_CH];
  int busy_first;
  int busy_cnt;

  function automatic bit qual(int k);
    return m_en[k] && (m_wid[k] != 0);
  endfunction

  function automatic int exp_first(int k);
    return qual(k) ? S + 2 + m_dly[k] : -1;
  endfunction

  function automatic int exp_cnt(int k);
    return qual(k) ? m_wid[k] : 0;
  endfunction

  function automatic int exp_busy();
    int e;
    e = 0;
    for (int k = 0; k < NUM_CH; k++)
      if (qual(k) && (m_dly[k] + m_wid[k] > e)) e = m_dly[k] + m_wid[k];
    return (e == 0) ? 1 : e;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NUM_CH; k++) begin
      m_en[k] = 1'b0; m_dly[k] = 0; m_wid[k] = 0;
    end
  endfunction

  task automatic send_frame(input bit en, input int ch, input int unsigned dly,
                            input int unsigned wid, input bit bad_csum, input int last_at,
                            input logic [7:0] hdr, output logic got_done, output logic got_err);
    logic [7:0] b [11];
    logic [3:0] ch4;
    ch4  = 4'(ch);
    b[0] = hdr;
    b[1] = {en, 3'b000, ch4};
    b[2] = dly[31:24]; b[3] = dly[23:16]; b[4] = dly[15:8]; b[5] = dly[7:0];
    b[6] = wid[31:24]; b[7] = wid[23:16]; b[8] = wid[15:8]; b[9] = wid[7:0];
    b[10] = 8'h00;
    for (int i = 1; i < 10; i++) b[10] = b[10] ^ b[i];
    if (bad_csum) b[10] = b[10] ^ 8'h01;
    for (int i = 0; i <= last_at; i++) begin
      @(posedge clk); #1;
      bus.cfg_data  = b[i];
      bus.cfg_valid = 1'b1;
      bus.cfg_last  = (i == last_at);
    end
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    bus.cfg_last  = 1'b0;
    got_done = bus.cfg_done;
    got_err  = bus.cfg_err;
  endtask

  // Fires one shot and records each gate's first high cycle and high count.
  task automatic run_shot(input bit retrig);
    int n;
    n = S + 8 + exp_busy() + (retrig ? 24 : 0);
    for (int k = 0; k < NUM_CH; k++) begin
      obs_first[k] = -1; obs_cnt[k] = 0;
    end
    busy_first = -1;
    busy_cnt   = 0;
    @(posedge clk); #1 bus.tstart = 1'b1;
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      if (t == S + 3)            bus.tstart = 1'b0;
      if (retrig && t == S + 8)  bus.tstart = 1'b1;
      if (retrig && t == S + 14) bus.tstart = 1'b0;
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        if (busy_first < 0) busy_first = t;
        busy_cnt++;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (bus.gate_out[k] === 1'b1) begin
          if (obs_first[k] < 0) obs_first[k] = t;
          obs_cnt[k]++;
        end
      end
    end
    bus.tstart = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.tstart = 1'b0; bus.cfg_data = 8'h00; bus.cfg_valid = 1'b0; bus.cfg_last = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.gate_out, bus.busy, bus.cfg_done, bus.cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gate=%b busy=%b done=%b err=%b, want all 0",
               bus.gate_out, bus.busy, bus.cfg_done, bus.cfg_err);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_shot(1'b0);
    checks++;
    if (busy_cnt !== 1 || obs_cnt[0] !== 0 || obs_cnt[3] !== 0) begin
      errors++;
      $display("FAIL reset_table_quiet: got busy_cnt=%0d gate0=%0d gate3=%0d, want 1 0 0",
               busy_cnt, obs_cnt[0], obs_cnt[3]);
    end
  endtask

  task automatic test_basic_gate();
    logic d, e;
    send_frame(1'b1, 0, 80, 720, 1'b0, 10, 8'hBD, d, e);
    checks++;
    if ({d, e} !== 2'b10) begin
      errors++; $display("FAIL basic_frame: got done/err=%b%b, want 10", d, e);
    end
    m_en[0] = 1'b1; m_dly[0] = 80; m_wid[0] = 720;
    repeat (3) @(posedge clk);
    run_shot(1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (obs_first[k] !== exp_first(k) || obs_cnt[k] !== exp_cnt(k)) begin
        errors++;
        $display("FAIL basic_gate%0d: got first=%0d cnt=%0d, want first=%0d cnt=%0d",
                 k, obs_first[k], obs_cnt[k], exp_first(k), exp_cnt(k));
      end
    end
    checks++;
    if (busy_first !== S + 1 || busy_cnt !== 800) begin
      errors++;
      $display("FAIL basic_busy: got first=%0d cnt=%0d, want %0d 800", busy_first, busy_cnt, S + 1);
    end
  endtask

  task automatic test_overlap();
    logic d, e;
    send_frame(1'b0, 0, 80, 720, 1'b0, 10, 8'hBD, d, e);
    m_en[0] = 1'b0;
    send_frame(1'b1, 1, 10, 5, 1'b0, 10, 8'hBD, d, e);
    m_en[1] = 1'b1; m_dly[1] = 10; m_wid[1] = 5;
    send_frame(1'b1, 2, 12, 1, 1'b0, 10, 8'hBD, d, e);
    m_en[2] = 1'b1; m_dly[2] = 12; m_wid[2] = 1;
    checks++;
    if ({d, e} !== 2'b10) begin
      errors++; $display("FAIL overlap_frame: got done/err=%b%b, want 10", d, e);
    end
    repeat (3) @(posedge clk);
    run_shot(1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (obs_first[k] !== exp_first(k) || obs_cnt[k] !== exp_cnt(k)) begin
        errors++;
        $display("FAIL overlap_gate%0d: got first=%0d cnt=%0d, want first=%0d cnt=%0d",
                 k, obs_first[k], obs_cnt[k], exp_first(k), exp_cnt(k));
      end
    end
    checks++;
    if (busy_first !== S + 1 || busy_cnt !== 15) begin
      errors++; $display("FAIL overlap_busy: got first=%0d cnt=%0d, want %0d 15",
                         busy_first, busy_cnt, S + 1);
    end
  endtask

  task automatic test_bad_frames();
    logic d, e;
    send_frame(1'b1, 1, 1, 1, 1'b1, 10, 8'hBD, d, e);
    checks++;
    if ({d, e} !== 2'b01) begin
      errors++; $display("FAIL bad_csum: got done/err=%b%b, want 01", d, e);
    end
    send_frame(1'b1, 1, 1, 1, 1'b0, 4, 8'hBD, d, e);
    checks++;
    if ({d, e} !== 2'b01) begin
      errors++; $display("FAIL early_last: got done/err=%b%b, want 01", d, e);
    end
    send_frame(1'b1, 1, 1, 1, 1'b0, 10, 8'h00, d, e);
    checks++;
    if ({d, e} !== 2'b00) begin
      errors++; $display("FAIL bad_header: got done/err=%b%b, want 00", d, e);
    end
    send_frame(1'b1, 5, 1, 1, 1'b0, 10, 8'hBD, d, e);
    checks++;
    if ({d, e} !== 2'b01) begin
      errors++; $display("FAIL bad_channel: got done/err=%b%b, want 01", d, e);
    end
    repeat (3) @(posedge clk);
    run_shot(1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (obs_first[k] !== exp_first(k) || obs_cnt[k] !== exp_cnt(k)) begin
        errors++;
        $display("FAIL bad_keep_gate%0d: got first=%0d cnt=%0d, want first=%0d cnt=%0d",
                 k, obs_first[k], obs_cnt[k], exp_first(k), exp_cnt(k));
      end
    end
  endtask

  task automatic test_midshot_reconfig();
    logic d1, e1, d2, e2;
    send_frame(1'b1, 0, 20, 30, 1'b0, 10, 8'hBD, d1, e1);
    m_en[0] = 1'b1; m_dly[0] = 20; m_wid[0] = 30;
    repeat (3) @(posedge clk);
    fork
      run_shot(1'b0);
      begin
        repeat (8) @(posedge clk);
        send_frame(1'b1, 0, 5, 7, 1'b0, 10, 8'hBD, d1, e1);
        send_frame(1'b1, 0, 9, 4, 1'b0, 10, 8'hBD, d2, e2);
      end
    join
    checks++;
    if ({d1, e1, d2, e2} !== 4'b1010) begin
      errors++; $display("FAIL midshot_frames: got %b%b %b%b, want 10 10", d1, e1, d2, e2);
    end
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (obs_first[k] !== exp_first(k) || obs_cnt[k] !== exp_cnt(k)) begin
        errors++;
        $display("FAIL midshot_cur_gate%0d: got first=%0d cnt=%0d, want first=%0d cnt=%0d",
                 k, obs_first[k], obs_cnt[k], exp_first(k), exp_cnt(k));
      end
    end
    m_dly[0] = 9; m_wid[0] = 4;
    run_shot(1'b0);
    for (int k = 0; k < NUM_CH; k++) begin
      checks++;
      if (obs_first[k] !== exp_first(k) || obs_cnt[k] !== exp_cnt(k)) begin
        errors++;
        $display("FAIL midshot_next_gate%0d: got first=%0d cnt=%0d, want first=%0d cnt=%0d",
                 k, obs_first[k], obs_cnt[k], exp_first(k), exp_cnt(k));
      end
    end
    checks++;
    if (busy_cnt !== exp_busy()) begin
      errors++; $display("FAIL midshot_busy: got %0d, want %0d", busy_cnt, exp_busy());
    end
  endtask

  task automatic test_retrigger_zero();
    logic d, e;
    send_frame(1'b1, 3, 40, 20, 1'b0, 10, 8'hBD, d, e);
    m_en[3] = 1'b1; m_dly[3] = 40; m_wid[3] = 20;
    repeat (3) @(posedge clk);
    run_shot(1'b1);
    checks++;
    if (busy_first !== S + 1 || busy_cnt !== 60 || obs_cnt[3] !== 20) begin
      errors++;
      $display("FAIL retrigger: got busy first=%0d cnt=%0d gate3=%0d, want %0d 60 20",
               busy_first, busy_cnt, obs_cnt[3], S + 1);
    end
    send_frame(1'b0, 0, 3, 5, 1'b0, 10, 8'hBD, d, e);
    send_frame(1'b1, 1, 3, 0, 1'b0, 10, 8'hBD, d, e);
    send_frame(1'b0, 2, 0, 9, 1'b0, 10, 8'hBD, d, e);
    send_frame(1'b1, 3, 7, 0, 1'b0, 10, 8'hBD, d, e);
    m_en[0] = 1'b0; m_dly[0] = 3; m_wid[0] = 5;
    m_en[1] = 1'b1; m_dly[1] = 3; m_wid[1] = 0;
    m_en[2] = 1'b0; m_dly[2] = 0; m_wid[2] = 9;
    m_en[3] = 1'b1; m_dly[3] = 7; m_wid[3] = 0;
    repeat (3) @(posedge clk);
    run_shot(1'b0);
    checks++;
    if (busy_first !== S + 1 || busy_cnt !== 1 ||
        (obs_cnt[0] + obs_cnt[1] + obs_cnt[2] + obs_cnt[3]) !== 0) begin
      errors++;
      $display("FAIL zero_width: got busy first=%0d cnt=%0d gates=%0d/%0d/%0d/%0d, want %0d 1 none",
               busy_first, busy_cnt, obs_cnt[0], obs_cnt[1], obs_cnt[2], obs_cnt[3], S + 1);
    end
  endtask

  task automatic test_random();
    logic d, e;
    bit en;
    int dly, wid;
    for (int it = 0; it < 6; it++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        en  = ($urandom_range(0, 3) != 0);
        dly = $urandom_range(0, 40);
        wid = $urandom_range(0, 30);
        send_frame(en, k, dly, wid, 1'b0, 10, 8'hBD, d, e);
        checks++;
        if ({d, e} !== 2'b10) begin
          errors++; $display("FAIL rand_frame it%0d ch%0d: got done/err=%b%b, want 10", it, k, d, e);
        end
        m_en[k] = en; m_dly[k] = dly; m_wid[k] = wid;
      end
      repeat (3) @(posedge clk);
      run_shot(1'b0);
      for (int k = 0; k < NUM_CH; k++) begin
        checks++;
        if (obs_first[k] !== exp_first(k) || obs_cnt[k] !== exp_cnt(k)) begin
          errors++;
          $display("FAIL rand_gate it%0d ch%0d: got first=%0d cnt=%0d, want first=%0d cnt=%0d",
                   it, k, obs_first[k], obs_cnt[k], exp_first(k), exp_cnt(k));
        end
      end
      checks++;
      if (busy_first !== S + 1 || busy_cnt !== exp_busy()) begin
        errors++;
        $display("FAIL rand_busy it%0d: got first=%0d cnt=%0d, want %0d %0d",
                 it, busy_first, busy_cnt, S + 1, exp_busy());
      end
    end
  endtask

  task automatic test_reset_midshot();
    logic d, e;
    send_frame(1'b1, 0, 2, 200, 1'b0, 10, 8'hBD, d, e);
    m_en[0] = 1'b1; m_dly[0] = 2; m_wid[0] = 200;
    repeat (3) @(posedge clk);
    @(posedge clk); #1 bus.tstart = 1'b1;
    repeat (S + 10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.gate_out[0] !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL midshot_active: got gate0=%b busy=%b, want 1 1",
                         bus.gate_out[0], bus.busy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.gate_out !== '0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_midshot: got gate=%b busy=%b, want 0 0", bus.gate_out, bus.busy);
    end
    bus.tstart = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_shot(1'b0);
    checks++;
    if (busy_cnt !== 1 || (obs_cnt[0] + obs_cnt[1] + obs_cnt[2] + obs_cnt[3]) !== 0) begin
      errors++; $display("FAIL reset_cleared: got busy_cnt=%0d gate0=%0d, want 1 0",
                         busy_cnt, obs_cnt[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic_gate();
    test_overlap();
    test_bad_frames();
    test_midshot_reconfig();
    test_retrigger_zero();
    test_random();
    test_reset_midshot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_gate_gen.md
# range_gate_gen

Multi-channel programmable range-gate generator for the lidar receive path. A rising edge on the laser-fire marker `tstart` starts a shared time-base. Each of `NUM_CH` gate outputs is then asserted for a programmable window, defined by a delay and a width counted in `clk` cycles. Per-channel timing is loaded at run time through the host byte stream (checksummed frames), and a new setting never takes effect in the middle of a shot.

## Interface
- `NUM_CH`, 4, number of gate channels (1–16)
- `CNT_W`, 32, width of the time-base, delay and width values
- `SYNC_STAGES`, 3, synchroniser depth on `tstart` (≥2)
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low; clock clk
- `tstart`  in  1  asynchronous fire marker; its rising edge starts a shot
- `cfg_data`  in  8  configuration byte
- `cfg_valid`  in  1  `cfg_data` is valid this cycle
- `cfg_last`  in  1  end-of-frame marker, qualified by `cfg_valid`
- `gate_out`  out  NUM_CH  gate outputs, registered
- `busy`  out  1  shot in progress
- `cfg_done`  out  1  one-cycle pulse when a frame is accepted
- `cfg_err`  out  1  one-cycle pulse when a frame is rejected

## Operation
- **Reset values:** all outputs 0. Every channel's delay, width and enable are 0, so the gates stay quiet until configured.
- **Frame format:** 11 bytes, in this order.
  - Byte 0: header `0xBD`.
  - Byte 1: `{en, 3'b0, ch[3:0]}`.
  - Bytes 2–5: delay, MSB first.
  - Bytes 6–9: width, MSB first.
  - Byte 10: XOR of bytes 1–9.
  - Values wider than `CNT_W` are truncated to the low `CNT_W` bits.
- **Parser states:** `IDLE`, `BODY`, `DISCARD`.
  - `IDLE`: `0xBD` → `BODY`. Any other byte → `DISCARD`, with no error.
  - `DISCARD`: stays until a byte with `cfg_last`, then → `IDLE`.
  - `BODY`: `cfg_last` before byte 10 → `cfg_err`, → `IDLE`.
  - `BODY`, byte 10 received: if the checksum is bad, `ch ≥ NUM_CH`, or `cfg_last` is low → `cfg_err`, no update. Otherwise → `cfg_done`, frame goes to pending.
  - If `cfg_last` is low on byte 10, the parser then → `DISCARD`.
- **Pending register:** one entry. A newer accepted frame overwrites a pending one (latest wins).
- **Apply rule:** the pending entry is written into the channel table on the first cycle with `busy` = 0. If `busy` = 0 when the frame is accepted, it is applied on the following cycle.
- **Shot start:**
  - `tstart` passes through `SYNC_STAGES` flops; an edge is "synced high, previous low".
  - An edge while `busy` = 0 sets `busy` = 1 and `cnt` = 0.
  - Edges while `busy` = 1 are ignored.
- **Gate equation:** for each channel k, `gate_out[k]` = en_k ∧ W_k ≠ 0 ∧ D_k ≤ cnt < D_k + W_k.
  - The sum is computed at `CNT_W`+1 bits, so there is no wrap.
- **Shot end:** `end_max` = max(D_k + W_k) over enabled channels with W_k ≠ 0. `busy` clears on the cycle after `cnt` = `end_max` − 1; `cnt` then holds at 0.
- **No active channels:** if no channel qualifies, an edge produces `busy` for exactly 1 cycle and no gates.
- **Counter saturation:** `cnt` saturates at all-ones and never wraps.
- **Reset mid-shot:** `gate_out`, `busy`, pending and the parser return to reset values immediately.

## Timing
- **Edge-to-busy latency:** a `tstart` rise sampled at edge 0 is detected at edge `SYNC_STAGES`. `busy` = 1 and `cnt` = 0 are visible after edge `SYNC_STAGES`+1.
- **Gate rise:** `gate_out[k]` rises one cycle after `cnt` = D_k. With D = 0, it rises one cycle after `cnt` starts.
- **Gate width:** the high time is exactly W_k cycles.
- **Config pulses:** `cfg_done` / `cfg_err` fire the cycle after byte 10 or the early `cfg_last`.
- **Config latency:** the table is updated at most 1 cycle after `cfg_done` when idle.
- **Simultaneous apply and shot start:** if a `tstart` edge and a pending apply fall on the same idle cycle, the apply happens first and the shot uses the new values.

## Structure
- **Package `range_gate_pkg`:** header constant `0xBD`, frame length 11, byte offsets, and the parser state enum.
- **Sub-module `gate_cfg_parser`:** byte counter, shift registers, checksum, and `cfg_done`/`cfg_err` generation.
- **Top level:** synchroniser, time-base, channel table, pending register, and a `NUM_CH`-wide generate loop for the comparators.

## Test plan
- **Basic gate:** configure ch0 D = 80, W = 720, en. Pulse `tstart` → `gate_out[0]` high for 720 cycles, rising `SYNC_STAGES`+82 cycles after the rise. `busy` low after `end_max` = 800.
- **Overlapping channels:** ch1 D = 10, W = 5; ch2 D = 12, W = 1. Pulse `tstart` → the gates overlap at `cnt` 12. `busy` lasts 15 cycles.
- **Bad frames:**
  - Corrupt checksum → `cfg_err`, and the next shot uses the old values.
  - Early `cfg_last` at byte 4 → `cfg_err`.
  - First byte `0x00` → silent discard.
- **Mid-shot reconfiguration:** send a frame for ch0 during a shot → the current shot is unchanged and the next shot uses the new D/W. Two frames during one shot → only the second is applied.
- **Retrigger and zero width:** a second `tstart` edge while `busy` → ignored. W = 0 or en = 0 → the gate stays low and `busy` is 1 cycle.
- **Reset mid-shot:** assert `rst_n` low in the middle of a shot → all outputs 0 immediately, and the channel table is cleared.
